mod_mul_barrett_sched: RTL and testbench

//  Round-robin scheduler sharing one pipelined 32b Barrett modular multiplier among NUM_REQ requesters.

---
 rtl/mod_mul_barrett_sched.sv | 162 ++++++++++++++++
 tb/tb_mod_mul_barrett_sched.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_barrett_sched.sv
// Round-robin scheduler sharing one pipelined Barrett modular multiplier among NUM_REQ requesters.
// Requester IDs ride a tag pipe matched to the multiplier latency; config reloads wait for drain.
module mod_mul_barrett_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DW      = 32,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CntW   = $clog2(LATENCY + 2)
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iClr,
  input  logic [NUM_REQ-1:0]    iReqValid,
  output logic [NUM_REQ-1:0]    oReqReady,
  input  logic [NUM_REQ*DW-1:0] iReqData0,
  input  logic [NUM_REQ*DW-1:0] iReqData1,
  input  logic                  iCfgValid,
  output logic                  oCfgReady,
  input  logic [5:0]            iCfgK,
  input  logic [2*DW-1:0]       iCfgU,
  input  logic [DW-1:0]         iCfgMod,
  output logic                  oMulEn,
  output logic                  oMulClr,
  output logic [5:0]            oMulK,
  output logic [2*DW-1:0]       oMulU,
  output logic [DW-1:0]         oMulMod,
  output logic [DW-1:0]         oMulData0,
  output logic [DW-1:0]         oMulData1,
  input  logic [DW-1:0]         iMulData,
  output logic                  oRspValid,
  output logic [IdW-1:0]        oRspId,
  output logic [DW-1:0]         oRspData,
  output logic                  oBusy
);

  localparam int unsigned SumW = IdW + 1;
  localparam logic [SumW-1:0] NumReqW = SumW'(NUM_REQ);

  typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     last_q, winner;
  logic [SumW-1:0]    sum;
  logic               found, grant_en, xfer, cfg_load, rsp_valid;
  logic [NUM_REQ-1:0] ready;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LATENCY:0]   tag_vld_q;
  logic [IdW-1:0]     tag_id_q [LATENCY+1];
  logic               mul_en_q, mul_clr_q;
  logic [DW-1:0]      data0_q, data1_q, mod_q;
  logic [5:0]         k_q;
  logic [2*DW-1:0]    u_q;

  // Rotating search starting just after the last granted requester.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, last_q} + SumW'(k + 1);
      if (sum >= NumReqW) sum = sum - NumReqW;
      if (!found && iReqValid[sum[IdW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IdW-1:0];
      end
    end
  end

  assign grant_en  = iRstN && !iClr && !iCfgValid && (state_q == StRun);
  assign xfer      = grant_en && found;
  assign rsp_valid = tag_vld_q[LATENCY];

  always_comb begin
    ready = '0;
    if (xfer) ready[winner] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !rsp_valid)      cnt_d = cnt_q + CntW'(1);
    else if (!xfer && rsp_valid) cnt_d = cnt_q - CntW'(1);
  end

  // Drain exits on the next-state count so LOAD follows the last response directly.
  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    unique case (state_q)
      StRun:   if (iCfgValid) state_d = StDrain;
      StDrain: if (cnt_d == '0) state_d = StLoad;
      StLoad: begin
        state_d  = StRun;
        cfg_load = 1'b1;
      end
      default: state_d = StRun;
    endcase
    if (iClr) begin
      state_d  = (state_q == StRun) ? StRun : StDrain;
      cfg_load = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q   <= StRun;
      last_q    <= IdW'(NUM_REQ - 1);
      cnt_q     <= '0;
      tag_vld_q <= '0;
      mul_en_q  <= 1'b0;
      mul_clr_q <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
      k_q       <= '0;
      u_q       <= '0;
      mod_q     <= '0;
    end else begin
      state_q   <= state_d;
      mul_en_q  <= 1'b1;
      mul_clr_q <= iClr;
      if (iClr) begin
        cnt_q     <= '0;
        tag_vld_q <= '0;
        data0_q   <= '0;
        data1_q   <= '0;
      end else begin
        cnt_q     <= cnt_d;
        tag_vld_q <= {tag_vld_q[LATENCY-1:0], xfer};
        if (xfer) begin
          data0_q <= iReqData0[winner*DW +: DW];
          data1_q <= iReqData1[winner*DW +: DW];
          last_q  <= winner;
        end
      end
      if (cfg_load) begin
        k_q   <= iCfgK;
        u_q   <= iCfgU;
        mod_q <= iCfgMod;
      end
    end
  end

  // IDs need no reset: they are only observed alongside a valid tag.
  always_ff @(posedge iClk) begin
    tag_id_q[0] <= winner;
    for (int i = 1; i <= LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  assign oReqReady = ready;
  assign oCfgReady = cfg_load && iRstN;
  assign oMulEn    = mul_en_q;
  assign oMulClr   = mul_clr_q;
  assign oMulK     = k_q;
  assign oMulU     = u_q;
  assign oMulMod   = mod_q;
  assign oMulData0 = data0_q;
  assign oMulData1 = data1_q;
  assign oRspValid = rsp_valid;
  assign oRspId    = rsp_valid ? tag_id_q[LATENCY] : '0;
  assign oRspData  = rsp_valid ? iMulData : '0;
  assign oBusy     = (cnt_q != '0) || (state_q != StRun);

endmodule

// File: tb/tb_mod_mul_barrett_sched.sv
// Directed bench for mod_mul_barrett_sched with a behavioural LATENCY-deep multiplier attached.
module tb_mod_mul_barrett_sched;
  localparam int N = 4;
  localparam int L = 10;

  logic         iClk = 1'b0;
  logic         iRstN = 1'b0;
  logic         iClr = 1'b0;
  logic [3:0]   iReqValid = '0;
  logic [3:0]   oReqReady;
  logic [127:0] iReqData0 = '0;
  logic [127:0] iReqData1 = '0;
  logic         iCfgValid = 1'b0;
  logic         oCfgReady;
  logic [5:0]   iCfgK = '0;
  logic [63:0]  iCfgU = '0;
  logic [31:0]  iCfgMod = '0;
  logic         oMulEn, oMulClr;
  logic [5:0]   oMulK;
  logic [63:0]  oMulU;
  logic [31:0]  oMulMod, oMulData0, oMulData1, iMulData, oRspData;
  logic         oRspValid, oBusy;
  logic [1:0]   oRspId;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mod_mul_barrett_sched #(.NUM_REQ(N), .LATENCY(L), .DW(32)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr),
    .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqData0(iReqData0), .iReqData1(iReqData1),
    .iCfgValid(iCfgValid), .oCfgReady(oCfgReady),
    .iCfgK(iCfgK), .iCfgU(iCfgU), .iCfgMod(iCfgMod),
    .oMulEn(oMulEn), .oMulClr(oMulClr), .oMulK(oMulK), .oMulU(oMulU), .oMulMod(oMulMod),
    .oMulData0(oMulData0), .oMulData1(oMulData1), .iMulData(iMulData),
    .oRspValid(oRspValid), .oRspId(oRspId), .oRspData(oRspData), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  // Behavioural multiplier: samples the issue registers, result LATENCY edges later.
  logic [31:0] mpipe [L];
  function automatic logic [31:0] modmul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] m);
    logic [63:0] p;
    if (m == 32'd0) return 32'd0;
    p = {32'h0, a} * {32'h0, b};
    return 32'(p % {32'h0, m});
  endfunction
  always @(posedge iClk) begin
    if (oMulClr) begin
      for (int i = 0; i < L; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= modmul(oMulData0, oMulData1, oMulMod);
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign iMulData = mpipe[L-1];

  int          iss_id[$], iss_cyc[$], rsp_id[$], rsp_cyc[$];
  logic [31:0] rsp_data[$];
  always @(negedge iClk) begin
    for (int i = 0; i < N; i++)
      if (iReqValid[i] && oReqReady[i]) begin
        iss_id.push_back(i);
        iss_cyc.push_back(cyc);
      end
    if (oRspValid) begin
      rsp_id.push_back(int'(oRspId));
      rsp_data.push_back(oRspData);
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs;
    iss_id.delete(); iss_cyc.delete();
    rsp_id.delete(); rsp_cyc.delete(); rsp_data.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    iReqData0[i*32 +: 32] = a;
    iReqData1[i*32 +: 32] = b;
  endtask

  task automatic reset_dut;
    tick();
    iRstN = 1'b0; iReqValid = '0; iClr = 1'b0; iCfgValid = 1'b0;
    tick();
    iRstN = 1'b1;
  endtask

  // Called just after a rising edge; returns cycles to oCfgReady (-1 on timeout).
  task automatic do_cfg(input logic [5:0] k, input logic [63:0] u, input logic [31:0] m,
                        output int lat, output int rdy_cyc, output int viol);
    int start;
    lat = -1; rdy_cyc = -1; viol = 0;
    iCfgValid = 1'b1; iCfgK = k; iCfgU = u; iCfgMod = m;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge iClk);
      if (oCfgReady) begin
        lat = cyc - start;
        rdy_cyc = cyc;
        break;
      end
      if (oReqReady != 4'b0) viol++;
    end
    tick();
    iCfgValid = 1'b0;
  endtask

  task automatic test_reset;
    iRstN = 1'b0; iReqValid = 4'hF;
    tick(); tick();
    @(negedge iClk);
    checks++;
    if ({oMulEn, oMulClr, oRspValid, oBusy, oCfgReady, oReqReady, oMulK} !== 15'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0",
               {oMulEn, oMulClr, oRspValid, oBusy, oCfgReady, oReqReady, oMulK});
    end
    checks++;
    if ({oMulMod, oMulU, oMulData0, oMulData1, oRspData} !== 192'b0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {oMulMod, oMulU, oMulData0, oMulData1});
    end
    tick();
    iRstN = 1'b1; iReqValid = '0;
    tick();
    @(negedge iClk);
    checks++;
    if (oMulEn !== 1'b1) begin
      failures++;
      $display("FAIL mul_en_after_reset: got %b want 1", oMulEn);
    end
  endtask

  task automatic test_basic;
    int lat, rc, viol, xc;
    tick();
    do_cfg(6'd13, 64'd8736, 32'd7681, lat, rc, viol);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL cfg_latency: got %0d want 2", lat);
    end
    checks++;
    if ({oMulK, oMulU, oMulMod} !== {6'd13, 64'd8736, 32'd7681}) begin
      failures++;
      $display("FAIL cfg_regs: got k=%0d u=%0d mod=%0d want 13 8736 7681", oMulK, oMulU, oMulMod);
    end
    clear_logs();
    iReqValid = 4'b0001;
    set_req(0, 32'd1467, 32'd2489);
    @(negedge iClk);
    xc = cyc;
    checks++;
    if (oReqReady !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant: got %b want 0001", oReqReady);
    end
    tick();
    iReqValid = '0;
    @(negedge iClk);
    checks++;
    if ({oMulData0, oMulData1} !== {32'd1467, 32'd2489}) begin
      failures++;
      $display("FAIL issue_regs: got %0d,%0d want 1467,2489", oMulData0, oMulData1);
    end
    idle(14);
    checks++;
    if (rsp_id.size() !== 1) begin
      failures++;
      $display("FAIL basic_rsp_count: got %0d want 1", rsp_id.size());
    end else begin
      checks++;
      if (rsp_cyc[0] !== xc + 11) begin
        failures++;
        $display("FAIL basic_rsp_latency: got %0d want %0d", rsp_cyc[0] - xc, 11);
      end
      checks++;
      if (rsp_id[0] !== 0 || rsp_data[0] !== 32'd2888) begin
        failures++;
        $display("FAIL basic_rsp: got id=%0d data=%0d want 0 2888", rsp_id[0], rsp_data[0]);
      end
    end
    checks++;
    if (oBusy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: got %b want 0", oBusy);
    end
  endtask

  task automatic test_round_robin;
    int lat, rc, viol;
    int sq[4] = '{1, 4, 9, 16};
    reset_dut();
    do_cfg(6'd13, 64'd8736, 32'd7681, lat, rc, viol);
    clear_logs();
    iReqValid = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(i + 1));
    repeat (12) tick();
    iReqValid = '0;
    idle(16);
    checks++;
    if (iss_id.size() !== 12 || rsp_id.size() !== 12) begin
      failures++;
      $display("FAIL rr_counts: got iss=%0d rsp=%0d want 12 12", iss_id.size(), rsp_id.size());
    end else begin
      for (int j = 0; j < 12; j++) begin
        checks++;
        if (iss_id[j] !== j % 4 || iss_cyc[j] !== iss_cyc[0] + j) begin
          failures++;
          $display("FAIL rr_grant[%0d]: got id=%0d dcyc=%0d want %0d %0d",
                   j, iss_id[j], iss_cyc[j] - iss_cyc[0], j % 4, j);
        end
        checks++;
        if (rsp_id[j] !== j % 4 || rsp_data[j] !== 32'(sq[j % 4]) ||
            rsp_cyc[j] !== iss_cyc[j] + 11) begin
          failures++;
          $display("FAIL rr_rsp[%0d]: got id=%0d data=%0d lat=%0d want %0d %0d 11",
                   j, rsp_id[j], rsp_data[j], rsp_cyc[j] - iss_cyc[j], j % 4, sq[j % 4]);
        end
      end
    end
  endtask

  task automatic test_clear;
    clear_logs();
    iReqValid = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd7);
    repeat (5) tick();
    iClr = 1'b1;
    @(negedge iClk);
    checks++;
    if (oReqReady !== 4'b0) begin
      failures++;
      $display("FAIL clr_no_grant: got %b want 0000", oReqReady);
    end
    tick();
    iClr = 1'b0; iReqValid = '0;
    @(negedge iClk);
    checks++;
    if ({oMulClr, oBusy, oMulData0, oMulData1} !== {1'b1, 1'b0, 64'h0}) begin
      failures++;
      $display("FAIL clr_pulse: got clr=%b busy=%b d0=%0d d1=%0d want 1 0 0 0",
               oMulClr, oBusy, oMulData0, oMulData1);
    end
    tick();
    @(negedge iClk);
    checks++;
    if (oMulClr !== 1'b0) begin
      failures++;
      $display("FAIL clr_one_cycle: got %b want 0", oMulClr);
    end
    idle(11);
    checks++;
    if (rsp_id.size() !== 0 || iss_id.size() !== 5) begin
      failures++;
      $display("FAIL clr_flush: got rsp=%0d iss=%0d want 0 5", rsp_id.size(), iss_id.size());
    end
    clear_logs();
    iReqValid = 4'b0100;
    set_req(2, 32'd3, 32'd5);
    tick();
    iReqValid = '0;
    idle(14);
    checks++;
    if (rsp_id.size() !== 1 || iss_id.size() !== 1) begin
      failures++;
      $display("FAIL clr_after_count: got rsp=%0d iss=%0d want 1 1", rsp_id.size(), iss_id.size());
    end else begin
      checks++;
      if (rsp_data[0] !== 32'd15 || rsp_id[0] !== 2 || rsp_cyc[0] !== iss_cyc[0] + 11) begin
        failures++;
        $display("FAIL clr_after_rsp: got data=%0d id=%0d lat=%0d want 15 2 11",
                 rsp_data[0], rsp_id[0], rsp_cyc[0] - iss_cyc[0]);
      end
    end
  endtask

  task automatic test_cfg_drain;
    int lat, rc, viol;
    int          eid[6] = '{3, 0, 1, 2, 3, 0};
    logic [31:0] edat[6] = '{40, 10, 20, 30, 40, 10};
    clear_logs();
    iReqValid = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd10);
    repeat (6) tick();
    iReqValid = 4'b0100;
    set_req(2, 32'h8000_0000, 32'd4);
    do_cfg(6'd32, 64'h1_0000_0001, 32'hFFFF_FFFF, lat, rc, viol);
    tick();
    iReqValid = '0;
    idle(14);
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL drain_ready_low: got %0d cycles with ready want 0", viol);
    end
    checks++;
    if ({oMulK, oMulU, oMulMod} !== {6'd32, 64'h1_0000_0001, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL drain_cfg_regs: got k=%0d u=%h mod=%h", oMulK, oMulU, oMulMod);
    end
    checks++;
    if (rsp_id.size() !== 7 || iss_id.size() !== 7) begin
      failures++;
      $display("FAIL drain_counts: got rsp=%0d iss=%0d want 7 7", rsp_id.size(), iss_id.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (rsp_id[j] !== eid[j] || rsp_data[j] !== edat[j]) begin
          failures++;
          $display("FAIL drain_old_rsp[%0d]: got id=%0d data=%0d want %0d %0d",
                   j, rsp_id[j], rsp_data[j], eid[j], edat[j]);
        end
      end
      checks++;
      if (rc !== rsp_cyc[5] + 1) begin
        failures++;
        $display("FAIL drain_cfg_ready_cycle: got %0d want %0d", rc, rsp_cyc[5] + 1);
      end
      checks++;
      if (iss_id[6] !== 2 || iss_cyc[6] !== rc + 1 || rsp_id[6] !== 2 || rsp_data[6] !== 32'd2) begin
        failures++;
        $display("FAIL drain_new_op: got id=%0d dcyc=%0d data=%0d want 2 1 2",
                 iss_id[6], iss_cyc[6] - rc, rsp_data[6]);
      end
    end
  endtask

  task automatic test_random;
    int          eid[10];
    logic [31:0] edat[10];
    logic [31:0] a, b;
    logic [63:0] p;
    int          r;
    clear_logs();
    for (int j = 0; j < 10; j++) begin
      r = int'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      p = {32'h0, a} * {32'h0, b};
      eid[j]  = r;
      edat[j] = 32'(p % 64'hFFFF_FFFF);
      iReqValid = 4'b0001 << r;
      set_req(r, a, b);
      tick();
    end
    iReqValid = '0;
    idle(14);
    checks++;
    if (rsp_id.size() !== 10 || iss_id.size() !== 10) begin
      failures++;
      $display("FAIL rand_counts: got rsp=%0d iss=%0d want 10 10", rsp_id.size(), iss_id.size());
    end else begin
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (iss_id[j] !== eid[j] || rsp_id[j] !== eid[j] || rsp_data[j] !== edat[j]) begin
          failures++;
          $display("FAIL rand_rsp[%0d]: got iss=%0d id=%0d data=%h want %0d %h",
                   j, iss_id[j], rsp_id[j], rsp_data[j], eid[j], edat[j]);
        end
      end
    end
  endtask

  task automatic test_single_hold;
    clear_logs();
    iReqValid = 4'b0010;
    set_req(1, 32'd7, 32'd9);
    repeat (8) tick();
    iReqValid = '0;
    idle(14);
    checks++;
    if (iss_id.size() !== 8 || rsp_id.size() !== 8) begin
      failures++;
      $display("FAIL hold_counts: got iss=%0d rsp=%0d want 8 8", iss_id.size(), rsp_id.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (iss_id[j] !== 1 || iss_cyc[j] !== iss_cyc[0] + j || rsp_data[j] !== 32'd63) begin
          failures++;
          $display("FAIL hold[%0d]: got id=%0d dcyc=%0d data=%0d want 1 %0d 63",
                   j, iss_id[j], iss_cyc[j] - iss_cyc[0], rsp_data[j], j);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    iReqValid = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 32'd2, 32'd3);
    repeat (4) tick();
    iRstN = 1'b0;
    tick();
    iRstN = 1'b1; iReqValid = '0;
    @(negedge iClk);
    clear_logs();
    checks++;
    if ({oMulEn, oMulClr, oRspValid, oBusy, oCfgReady, oMulK} !== 11'b0 ||
        {oMulMod, oMulU, oMulData0, oMulData1} !== 160'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got en=%b busy=%b rsp=%b mod=%h d0=%h",
               oMulEn, oBusy, oRspValid, oMulMod, oMulData0);
    end
    tick();
    idle(2);
    iReqValid = 4'hF;
    tick();
    iReqValid = '0;
    idle(16);
    checks++;
    if (iss_id.size() !== 1 || rsp_id.size() !== 1) begin
      failures++;
      $display("FAIL mid_reset_counts: got iss=%0d rsp=%0d want 1 1", iss_id.size(), rsp_id.size());
    end else begin
      checks++;
      if (iss_id[0] !== 0 || rsp_id[0] !== 0 || rsp_cyc[0] !== iss_cyc[0] + 11) begin
        failures++;
        $display("FAIL mid_reset_first: got iss=%0d rsp=%0d lat=%0d want 0 0 11",
                 iss_id[0], rsp_id[0], rsp_cyc[0] - iss_cyc[0]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_clear();
    test_cfg_drain();
    test_random();
    test_single_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
